// File: rtl/reg_bus_pkg.sv
// Shared definitions for the two-master peripheral register bus arbiter.
package reg_bus_pkg;

    localparam int unsigned DEF_INDEX_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant logic. REG_ARB_ROUND_ROBIN_EN selects round-robin tie breaking;
// otherwise requester 0 has fixed priority and no pointer state exists.
module rr_arbiter2
    import reg_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

`ifdef REG_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_o = (last_q == M1) ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? M1 : M0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt_o = 2'b00;
        if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{clk, reset_n, en_i};
`endif

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two masters onto the strobe-based register bus, one access per four cycles.
// Tie policy set by REG_ARB_ROUND_ROBIN_EN inside rr_arbiter2.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   m0_req,
    input  logic                   m0_write,
    input  logic [INDEX_WIDTH-1:0] m0_index,
    input  logic [DATA_WIDTH-1:0]  m0_wdata,
    output logic                   m0_ack,
    output logic [DATA_WIDTH-1:0]  m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_write,
    input  logic [INDEX_WIDTH-1:0] m1_index,
    input  logic [DATA_WIDTH-1:0]  m1_wdata,
    output logic                   m1_ack,
    output logic [DATA_WIDTH-1:0]  m1_rdata,
    output logic [INDEX_WIDTH-1:0] register_index_o,
    output logic                   register_read_o,
    output logic                   register_write_o,
    output logic [DATA_WIDTH-1:0]  register_write_value_o,
    input  logic [DATA_WIDTH-1:0]  register_read_value_i,
    output logic [1:0]             grant_o
);

    arb_state_e             state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   write_q, write_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   rd_stb_q, rd_stb_d;
    logic                   wr_stb_q, wr_stb_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]  rdata1_q, rdata1_d;
    logic [1:0]             arb_gnt;
    logic                   sel_write;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req0_i  (m0_req),
        .req1_i  (m1_req),
        .en_i    (state_q == StIdle),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        write_d   = write_q;
        index_d   = index_q;
        wdata_d   = wdata_q;
        rd_stb_d  = 1'b0;
        wr_stb_d  = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        sel_write = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_gnt != 2'b00) begin
                    sel_write = arb_gnt[1] ? m1_write : m0_write;
                    grant_d   = arb_gnt;
                    write_d   = sel_write;
                    index_d   = arb_gnt[1] ? m1_index : m0_index;
                    wdata_d   = arb_gnt[1] ? m1_wdata : m0_wdata;
                    rd_stb_d  = !sel_write;
                    wr_stb_d  = sel_write;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // Peripheral data is valid only now; capture it into the owner's rdata.
                if (grant_q[1]) begin
                    ack1_d   = 1'b1;
                    rdata1_d = write_q ? '0 : register_read_value_i;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = write_q ? '0 : register_read_value_i;
                end
                state_d = StResp;
            end
            StResp: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            grant_q  <= 2'b00;
            write_q  <= 1'b0;
            index_q  <= '0;
            wdata_q  <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            index_q  <= index_d;
            wdata_q  <= wdata_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_ack                 = ack0_q;
    assign m1_ack                 = ack1_q;
    assign m0_rdata               = rdata0_q;
    assign m1_rdata               = rdata1_q;
    assign register_index_o       = index_q;
    assign register_read_o        = rd_stb_q;
    assign register_write_o       = wr_stb_q;
    assign register_write_value_o = wdata_q;
    assign grant_o                = grant_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed-vector bench for reg_bus_arbiter; tie expectations follow REG_ARB_ROUND_ROBIN_EN.
module tb_reg_bus_arbiter;

`ifdef REG_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [11:0] m0_index, m1_index;
    logic [15:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [11:0] register_index_o;
    logic        register_read_o, register_write_o;
    logic [15:0] register_write_value_o;
    logic [15:0] register_read_value_i = 16'h0000;
    logic [1:0]  grant_o;
    logic [15:0] periph_xor;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Peripheral model: returns index XOR a per-test pattern, registered on the strobe edge.
    always @(posedge clk) begin
        if (register_read_o) begin
            register_read_value_i <= {4'h0, register_index_o} ^ periph_xor;
        end
    end

    reg_bus_arbiter dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .m0_req                 (m0_req),
        .m0_write               (m0_write),
        .m0_index               (m0_index),
        .m0_wdata               (m0_wdata),
        .m0_ack                 (m0_ack),
        .m0_rdata               (m0_rdata),
        .m1_req                 (m1_req),
        .m1_write               (m1_write),
        .m1_index               (m1_index),
        .m1_wdata               (m1_wdata),
        .m1_ack                 (m1_ack),
        .m1_rdata               (m1_rdata),
        .register_index_o       (register_index_o),
        .register_read_o        (register_read_o),
        .register_write_o       (register_write_o),
        .register_write_value_o (register_write_value_o),
        .register_read_value_i  (register_read_value_i),
        .grant_o                (grant_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic rd, input logic wr,
                             input logic [11:0] idx, input logic [1:0] gnt);
        check({tag, ".rd"}, {31'd0, register_read_o}, {31'd0, rd});
        check({tag, ".wr"}, {31'd0, register_write_o}, {31'd0, wr});
        check({tag, ".idx"}, {20'd0, register_index_o}, {20'd0, idx});
        check({tag, ".gnt"}, {30'd0, grant_o}, {30'd0, gnt});
    endtask

    task automatic check_acks(input string tag, input logic a0, input logic a1);
        check({tag, ".ack0"}, {31'd0, m0_ack}, {31'd0, a0});
        check({tag, ".ack1"}, {31'd0, m1_ack}, {31'd0, a1});
    endtask

    initial begin
        reset_n    = 1'b0;
        m0_req     = 1'b0;
        m0_write   = 1'b0;
        m0_index   = 12'h000;
        m0_wdata   = 16'h0000;
        m1_req     = 1'b0;
        m1_write   = 1'b0;
        m1_index   = 12'h000;
        m1_wdata   = 16'h0000;
        periph_xor = 16'h0000;

        #12;
        check_bus("reset", 1'b0, 1'b0, 12'h000, 2'b00);
        check_acks("reset", 1'b0, 1'b0);
        check("reset.wv", {16'd0, register_write_value_o}, 32'h0);
        check("reset.rdata0", {16'd0, m0_rdata}, 32'h0);
        check("reset.rdata1", {16'd0, m1_rdata}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // m0 single read of index 1
        m0_req   = 1'b1;
        m0_write = 1'b0;
        m0_index = 12'h001;
        tick();
        check_bus("rd0.issue", 1'b1, 1'b0, 12'h001, 2'b01);
        tick();
        check_bus("rd0.wait", 1'b0, 1'b0, 12'h001, 2'b01);
        check_acks("rd0.wait", 1'b0, 1'b0);
        tick();
        check_acks("rd0.resp", 1'b1, 1'b0);
        check("rd0.rdata", {16'd0, m0_rdata}, 32'h0001);
        m0_req = 1'b0;
        tick();
        check_acks("rd0.idle", 1'b0, 1'b0);
        check_bus("rd0.idle", 1'b0, 1'b0, 12'h001, 2'b00);
        check("rd0.hold", {16'd0, m0_rdata}, 32'h0001);

        // m0 write; inputs change and req drops right after grant
        m0_req   = 1'b1;
        m0_write = 1'b1;
        m0_index = 12'h0AB;
        m0_wdata = 16'h1111;
        tick();
        check_bus("stab.issue", 1'b0, 1'b1, 12'h0AB, 2'b01);
        check("stab.wv", {16'd0, register_write_value_o}, 32'h1111);
        m0_index = 12'hFFF;
        m0_wdata = 16'h2222;
        m0_write = 1'b0;
        m0_req   = 1'b0;
        tick();
        check_bus("stab.wait", 1'b0, 1'b0, 12'h0AB, 2'b01);
        check("stab.wv_hold", {16'd0, register_write_value_o}, 32'h1111);
        tick();
        check_acks("stab.resp", 1'b1, 1'b0);
        check("stab.rdata", {16'd0, m0_rdata}, 32'h0000);
        tick();
        check_bus("stab.idle", 1'b0, 1'b0, 12'h0AB, 2'b00);

        // m1 read of index 5
        periph_xor = 16'h5A00;
        m1_req     = 1'b1;
        m1_write   = 1'b0;
        m1_index   = 12'h005;
        tick();
        check_bus("rd1.issue", 1'b1, 1'b0, 12'h005, 2'b10);
        tick();
        tick();
        check_acks("rd1.resp", 1'b0, 1'b1);
        check("rd1.rdata", {16'd0, m1_rdata}, 32'h5A05);
        check("rd1.m0hold", {16'd0, m0_rdata}, 32'h0000);
        m1_req = 1'b0;
        tick();

        // m1 write of 16'hBEEF to index 12'h020
        m1_req   = 1'b1;
        m1_write = 1'b1;
        m1_index = 12'h020;
        m1_wdata = 16'hBEEF;
        tick();
        check_bus("wr1.issue", 1'b0, 1'b1, 12'h020, 2'b10);
        check("wr1.wv", {16'd0, register_write_value_o}, 32'hBEEF);
        tick();
        check_bus("wr1.wait", 1'b0, 1'b0, 12'h020, 2'b10);
        tick();
        check_acks("wr1.resp", 1'b0, 1'b1);
        check("wr1.rdata", {16'd0, m1_rdata}, 32'h0000);
        m1_req = 1'b0;
        tick();
        check_acks("wr1.idle", 1'b0, 1'b0);
        check("wr1.gnt", {30'd0, grant_o}, 32'h0);

        // Contention: last grant was m1, so round-robin starts with m0
        periph_xor = 16'hC0C0;
        m0_req     = 1'b1;
        m0_write   = 1'b0;
        m0_index   = 12'h000;
        m1_req     = 1'b1;
        m1_write   = 1'b0;
        m1_index   = 12'h001;
        for (int k = 0; k < 4; k++) begin
            logic win;
            win = RR ? k[0] : 1'b0;
            tick();
            check_bus($sformatf("cont%0d.issue", k), 1'b1, 1'b0, {11'd0, win},
                      win ? 2'b10 : 2'b01);
            tick();
            check("cont.wait_rd", {31'd0, register_read_o}, 32'h0);
            tick();
            check_acks($sformatf("cont%0d.resp", k), !win, win);
            check($sformatf("cont%0d.rdata", k),
                  {16'd0, (win ? m1_rdata : m0_rdata)}, {16'd0, 16'hC0C0 ^ {15'd0, win}});
            if (k == 3) m0_req = 1'b0;
            tick();
            check("cont.idle_rd", {31'd0, register_read_o}, 32'h0);
        end
        tick();
        check_bus("cont.m1", 1'b1, 1'b0, 12'h001, 2'b10);
        tick();
        tick();
        check_acks("cont.m1resp", 1'b0, 1'b1);
        m1_req = 1'b0;
        tick();

        // Reset during WAIT, then pending m1 request served afresh
        m1_req   = 1'b1;
        m1_index = 12'h007;
        tick();
        check_bus("rst.issue", 1'b1, 1'b0, 12'h007, 2'b10);
        tick();
        reset_n = 1'b0;
        #1;
        check_bus("rst.async", 1'b0, 1'b0, 12'h000, 2'b00);
        check_acks("rst.async", 1'b0, 1'b0);
        check("rst.rdata1", {16'd0, m1_rdata}, 32'h0);
        check("rst.wv", {16'd0, register_write_value_o}, 32'h0);
        tick();
        check_acks("rst.held", 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        check_bus("rst.reissue", 1'b1, 1'b0, 12'h007, 2'b10);
        tick();
        check_acks("rst.wait", 1'b0, 1'b0);
        tick();
        check_acks("rst.resp", 1'b0, 1'b1);
        check("rst.rdata", {16'd0, m1_rdata}, 32'h0000C0C7);
        m1_req = 1'b0;
        tick();
        check_bus("rst.idle", 1'b0, 1'b0, 12'h007, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-master arbiter for the 12-bit-index / 16-bit-data peripheral register bus. It lets the ulisp core and a second master (a sprite/tile copy engine) share the strobe-based register port that feeds the display controller and input registers. Each master gets a request/acknowledge handshake. The arbiter serialises accesses, drives single-cycle read/write strobes, and returns the registered read value to the owning master.

## Interface
- INDEX_WIDTH, 12, register index width
- DATA_WIDTH, 16, register data width

- clk  in  1  system clock (25 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; hold high until ack
- m0_write / m1_write  in  1  1 = write, 0 = read
- m0_index / m1_index  in  INDEX_WIDTH  register index
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_WIDTH  read result, valid while ack is high
- register_index_o  out  INDEX_WIDTH  bus index
- register_read_o  out  1  one-cycle read strobe
- register_write_o  out  1  one-cycle write strobe
- register_write_value_o  out  DATA_WIDTH  bus write data
- register_read_value_i  in  DATA_WIDTH  peripheral read data, registered by peripheral on strobe edge
- grant_o  out  2  one-hot current owner, 0 when idle

## Operation
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- **IDLE:** any req high selects a winner.
  - On that clock edge the arbiter latches the winner's write, index and wdata, sets grant_o, and goes to ISSUE.
  - Master inputs are ignored after latching.
- **ISSUE:** exactly one of register_read_o or register_write_o is high, with the latched index and value. Next state is WAIT.
- **WAIT:** strobes low. register_read_value_i is valid this cycle and is captured at the clock edge. Next state is RESP.
- **RESP:** the winner's ack is high for one cycle.
  - rdata carries the captured value for a read, and 0 for a write.
  - Next state is IDLE. grant_o clears on entry to IDLE.
- req is not sampled in ISSUE, WAIT or RESP. A master that holds req after its ack competes again in the next IDLE cycle.
- Non-owner ack is always 0. Non-owner rdata holds its last value.
- Bus outputs outside ISSUE: strobes 0; index and write value hold the last latched values.
- A request that drops before ack is protocol misuse. The latched transaction still completes and acks.

## Timing
- Reset values (asynchronous): state IDLE, all strobes 0, acks 0, grant_o 0, rdata 0, index/write value 0, round-robin pointer "last = m1".
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately.
  - The transaction is abandoned with no ack.
  - A strobe may be cut short.
- Latency: req sampled in IDLE at cycle N, strobe at N+1, ack at N+3.
- Throughput: next IDLE sample at N+4, i.e. at most one access per 4 cycles.
- Simultaneous requests in IDLE: resolved per Configuration; the loser keeps waiting.

## Configuration
- REG_ARB_ROUND_ROBIN_EN defined:
  - On a tie, the master not granted last wins.
  - The pointer updates on every grant.
  - Neither master can be starved.
- Undefined: fixed priority; m0 always wins a tie, and the pointer logic is absent.

## Structure
- Shared package reg_bus_pkg holds:
  - INDEX_WIDTH/DATA_WIDTH defaults
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the master-id constants M0/M1
- One sub-module, rr_arbiter2:
  - combinational grant from two reqs plus the last-grant bit
  - last-grant register with enable
  - macro-dependent logic lives here

## Test plan
- **Single read:** m0 reads index 1 while the peripheral returns 16'h0001.
  - register_read_o pulses at N+1 with index 1.
  - m0_ack at N+3 with m0_rdata = 16'h0001.
  - m1_ack stays 0.
- **Single write:** m1 writes 16'hBEEF to index 12'h020.
  - register_write_o pulses one cycle with the correct index and value.
  - m1_ack at N+3 with m1_rdata = 0.
- **Contention with REG_ARB_ROUND_ROBIN_EN:** both masters hold req for reads of indices 0 and 1.
  - Grants alternate m0, m1, m0, m1.
  - Strobes are exactly 4 cycles apart.
- **Contention without the macro:** both masters hold req.
  - m0 is granted every time while held.
  - m1 is granted only after m0 drops req.
- **Input stability:** m0 changes index and wdata in the cycle after grant.
  - The bus still shows the originally latched values.
- **Reset mid-transaction:** assert reset_n = 0 during WAIT.
  - All outputs go to 0 the same cycle, and no ack occurs.
  - After release, a pending m1 req is served normally, with ack at N+3 from its first IDLE sample.
